// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam int MEMREAD_BIT  = 0;
    localparam int MEMWRITE_BIT = 1;
    localparam int CTRL_MEM_W   = 2;
    localparam int CTRL_WB_W    = 2;
    localparam int REG_W        = 5;

    // Exactly one of MemRead/MemWrite set; 11 is illegal, 00 is a non-memory op.
    function automatic logic is_mem_op(input logic [CTRL_MEM_W-1:0] ctrl);
        return ctrl[MEMREAD_BIT] ^ ctrl[MEMWRITE_BIT];
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage between EX_MEM and MEM_WB: variable-latency load/store with upstream stall,
// bubble insertion toward MEM_WB, illegal-control detection and an access timeout.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CTRL_MEM_W-1:0] control_mem_in,
    input  logic [CTRL_WB_W-1:0]  control_wb_in,
    input  logic [DATA_W-1:0]     ALU_result_in,
    input  logic [DATA_W-1:0]     Write_data_in,
    input  logic [REG_W-1:0]      Write_reg_in,
    mem_access_stage_if.master    dmem,
    output logic                  stall,
    output logic                  mem_err,
    output logic [CTRL_WB_W-1:0]  control_wb_out,
    output logic [DATA_W-1:0]     Read_data_out,
    output logic [DATA_W-1:0]     ALU_result_out,
    output logic [REG_W-1:0]      Write_reg_out
);

    state_t                state;
    logic [CTRL_MEM_W-1:0] h_mem;
    logic [CTRL_WB_W-1:0]  h_wb;
    logic [DATA_W-1:0]     h_alu;
    logic [DATA_W-1:0]     h_wdata;
    logic [REG_W-1:0]      h_reg;
    logic [DATA_W-1:0]     rd_q;
    logic [CNT_W-1:0]      cnt;
    logic                  timeout_hit;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            h_mem   <= '0;
            h_wb    <= '0;
            h_alu   <= '0;
            h_wdata <= '0;
            h_reg   <= '0;
            rd_q    <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem_op(control_mem_in)) begin
                        h_mem   <= control_mem_in;
                        h_wb    <= control_wb_in;
                        h_alu   <= ALU_result_in;
                        h_wdata <= Write_data_in;
                        h_reg   <= Write_reg_in;
                        cnt     <= '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem.ack) begin
                        rd_q  <= h_mem[MEMREAD_BIT] ? dmem.rdata : '0;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        // Squash: the instruction retires with no register write-back.
                        h_wb  <= '0;
                        rd_q  <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        stall          = 1'b0;
        mem_err        = 1'b0;
        control_wb_out = '0;
        Read_data_out  = '0;
        ALU_result_out = '0;
        Write_reg_out  = '0;
        dmem.req       = 1'b0;
        dmem.we        = 1'b0;
        dmem.addr      = '0;
        dmem.wdata     = '0;
        // Outputs are gated by rst_n so the IDLE pass-through cannot leak inputs during reset.
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (control_mem_in == '0) begin
                        control_wb_out = control_wb_in;
                        ALU_result_out = ALU_result_in;
                        Write_reg_out  = Write_reg_in;
                    end else if (is_mem_op(control_mem_in)) begin
                        stall = 1'b1;
                    end else begin
                        mem_err = 1'b1;
                    end
                end
                ACCESS: begin
                    stall      = 1'b1;
                    dmem.req   = 1'b1;
                    dmem.we    = h_mem[MEMWRITE_BIT];
                    dmem.addr  = h_alu;
                    dmem.wdata = h_wdata;
                    mem_err    = !dmem.ack && timeout_hit;
                end
                DONE: begin
                    control_wb_out = h_wb;
                    Read_data_out  = rd_q;
                    ALU_result_out = h_alu;
                    Write_reg_out  = h_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage: per-instruction expected cycle streams
// are queued at issue time and compared by an independent negedge monitor.
module tb_mem_access_stage;

    localparam int DW = 32;
    localparam int T  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  control_mem_in;
    logic [1:0]  control_wb_in;
    logic [31:0] ALU_result_in;
    logic [31:0] Write_data_in;
    logic [4:0]  Write_reg_in;
    logic        stall, mem_err;
    logic [1:0]  control_wb_out;
    logic [31:0] Read_data_out, ALU_result_out;
    logic [4:0]  Write_reg_out;

    mem_access_stage_if #(.DATA_W(DW)) dmem ();

    mem_access_stage #(.DATA_W(DW), .TIMEOUT(T), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .control_mem_in (control_mem_in),
        .control_wb_in  (control_wb_in),
        .ALU_result_in  (ALU_result_in),
        .Write_data_in  (Write_data_in),
        .Write_reg_in   (Write_reg_in),
        .dmem           (dmem.master),
        .stall          (stall),
        .mem_err        (mem_err),
        .control_wb_out (control_wb_out),
        .Read_data_out  (Read_data_out),
        .ALU_result_out (ALU_result_out),
        .Write_reg_out  (Write_reg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, err, req, we;
        logic [31:0] addr, wdata;
        logic [1:0]  wb;
        logic [31:0] rd, alu;
        logic [4:0]  rg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t bubble();
        exp_t e;
        e.stall = 0; e.err = 0; e.req = 0; e.we = 0;
        e.addr = 0; e.wdata = 0; e.wb = 0; e.rd = 0; e.alu = 0; e.rg = 0;
        return e;
    endfunction

    // Monitor: every cycle that has an expectation is compared against the DUT outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("stall",    32'(stall),          32'(e.stall));
                check("mem_err",  32'(mem_err),        32'(e.err));
                check("req",      32'(dmem.req),       32'(e.req));
                check("we",       32'(dmem.we),        32'(e.we));
                check("addr",     dmem.addr,           e.addr);
                check("wdata",    dmem.wdata,          e.wdata);
                check("wb_out",   32'(control_wb_out), 32'(e.wb));
                check("rd_out",   Read_data_out,       e.rd);
                check("alu_out",  ALU_result_out,      e.alu);
                check("reg_out",  32'(Write_reg_out),  32'(e.rg));
            end
        end
    end

    // Drive one cycle of upstream and memory inputs, queue its expectation, advance to next edge.
    task automatic cycle_drive(input logic [1:0] cm, input logic [1:0] wb, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [4:0] rg, input logic ack,
                               input logic [31:0] rdata, input exp_t e);
        control_mem_in = cm;
        control_wb_in  = wb;
        ALU_result_in  = alu;
        Write_data_in  = wd;
        Write_reg_in   = rg;
        dmem.ack       = ack;
        dmem.rdata     = rdata;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input logic [1:0] wb, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] rg);
        exp_t e;
        e = bubble();
        e.wb = wb; e.alu = alu; e.rg = rg;
        cycle_drive(2'b00, wb, alu, wd, rg, 1'($urandom_range(0, 1)), $urandom, e);
    endtask

    task automatic run_illegal(input logic [1:0] wb, input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] rg);
        exp_t e;
        e = bubble();
        e.err = 1;
        cycle_drive(2'b11, wb, alu, wd, rg, 1'($urandom_range(0, 1)), $urandom, e);
    endtask

    // k = ACCESS cycle carrying the ack; k > T means memory never answers.
    task automatic run_mem(input logic is_store, input logic [1:0] wb, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [4:0] rg, input int k,
                           input logic [31:0] rdata);
        exp_t       e;
        logic [1:0] cm;
        int         n;
        bit         acked;
        cm    = is_store ? 2'b10 : 2'b01;
        acked = (k <= T);
        n     = acked ? k : T;
        e = bubble();
        e.stall = 1;
        cycle_drive(cm, wb, alu, wd, rg, 1'($urandom_range(0, 1)), $urandom, e);
        for (int j = 1; j <= n; j++) begin
            e = bubble();
            e.stall = 1; e.req = 1; e.we = is_store; e.addr = alu; e.wdata = wd;
            e.err = !acked && (j == T);
            cycle_drive(cm, wb, alu, wd, rg, acked && (j == k),
                        (acked && j == k) ? rdata : $urandom, e);
        end
        e = bubble();
        e.wb  = acked ? wb : 2'b00;
        e.rd  = (acked && !is_store) ? rdata : 32'h0;
        e.alu = alu;
        e.rg  = rg;
        cycle_drive(cm, wb, alu, wd, rg, 1'($urandom_range(0, 1)), $urandom, e);
    endtask

    initial begin
        rst_n          = 1'b0;
        control_mem_in = 2'b00;
        control_wb_in  = 2'b11;
        ALU_result_in  = 32'hCAFE_F00D;
        Write_data_in  = 32'h1111_2222;
        Write_reg_in   = 5'd9;
        dmem.ack       = 1'b1;
        dmem.rdata     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        repeat (2) begin
            exp_q.push_back(bubble());
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Directed cases.
        run_alu(2'b10, 32'h1234, 32'h0, 5'd5);
        run_mem(1'b0, 2'b11, 32'h40, 32'h0, 5'd7, 1, 32'hDEAD_BEEF);
        run_mem(1'b1, 2'b00, 32'h80, 32'hA5A5_A5A5, 5'd3, 3, 32'h0);
        run_mem(1'b0, 2'b11, 32'h100, 32'h0, 5'd12, T + 1, 32'h0);
        run_illegal(2'b11, 32'h55, 32'h66, 5'd8);

        // Reset in the middle of an access: outputs drop at once, no result follows.
        begin
            exp_t e;
            e = bubble();
            e.stall = 1;
            cycle_drive(2'b01, 2'b11, 32'h200, 32'h0, 5'd4, 1'b0, 32'h0, e);
            e = bubble();
            e.stall = 1; e.req = 1; e.addr = 32'h200;
            cycle_drive(2'b01, 2'b11, 32'h200, 32'h0, 5'd4, 1'b0, 32'h0, e);
            rst_n = 1'b0;
            exp_q.push_back(bubble());
            #1;
            check("rst_req_drop",   32'(dmem.req), 32'h0);
            check("rst_stall_drop", 32'(stall),    32'h0);
            @(posedge clk);
            #1;
            exp_q.push_back(bubble());
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            run_alu(2'b01, 32'h0000_0ABC, 32'h0, 5'd17);
        end

        // Randomized instruction stream.
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)
                run_alu(2'($urandom), $urandom, $urandom, 5'($urandom));
            else if (sel < 9)
                run_mem(1'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom),
                        $urandom_range(1, T + 2), $urandom);
            else
                run_illegal(2'($urandom), $urandom, $urandom, 5'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
